// File: rtl/conv_accelerator.sv
// Single-engine 2-D convolution accelerator: loads weights and a multi-channel IF from RAM,
// MACs one OF plane tap by tap and writes it back. Define RELU_EN to clamp negative results to 0.
module conv_accelerator #(
    parameter int DATA_WIDTH  = 16,
    parameter int ADDR_WIDTH  = 32,
    parameter int FRAC_BITS   = 8,
    parameter int ACC_WIDTH   = 40,
    parameter int MAX_W_WORDS = 675
) (
    input  logic                  ACCELERATOR_Clk_50,
    input  logic                  ACCELERATOR_Reset,
    input  logic [DATA_WIDTH-1:0] ACCELERATOR_DATA_IN,
    input  logic [ADDR_WIDTH-1:0] ACCELERATOR_ADDR_OFFSET,
    input  logic [9:0]            ACCELERATOR_IF_ROWS,
    input  logic [10:0]           ACCELERATOR_IF_COLUMS,
    input  logic [1:0]            ACCELERATOR_IF_CHANNELS,
    input  logic [9:0]            ACCELERATOR_OF_ROWS,
    input  logic [10:0]           ACCELERATOR_OF_COLUMS,
    input  logic [3:0]            ACCELERATOR_W_ROWS,
    input  logic [3:0]            ACCELERATOR_W_COLUMS,
    input  logic [1:0]            ACCELERATOR_W_CHANNELS,
    input  logic                  ACCELERATOR_SAME_W,
    input  logic [3:0]            ACCELERATOR_CONV_STRIDE,
    input  logic                  ACCELERATOR_START,
    input  logic                  ACCELERATOR_FINISHED_OK,
    output logic [DATA_WIDTH-1:0] ACCELERATOR_DATA_OUT,
    output logic [ADDR_WIDTH-1:0] ACCELERATOR_MEM_ADDR,
    output logic                  ACCELERATOR_MEM_WE,
    output logic                  ACCELERATOR_MEM_RE,
    output logic                  ACCELERATOR_FINISHED,
    output logic [2:0]            dbg_state
);
    localparam int IDX_W = $clog2(MAX_W_WORDS);
    localparam logic signed [ACC_WIDTH-1:0] SAT_MAX =
        {{(ACC_WIDTH-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
    localparam logic signed [ACC_WIDTH-1:0] SAT_MIN =
        {{(ACC_WIDTH-DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};

    typedef enum logic [2:0] {
        S_IDLE, S_W_RD, S_W_CAP, S_CONV_RD, S_CONV_MAC, S_WRITE, S_DONE
    } state_t;

    // Host handshake: START is taken only in IDLE; FINISHED stays high in DONE until
    // FINISHED_OK is seen, and drops on the following edge as the FSM returns to IDLE.
    state_t                       state, state_n;
    logic [IDX_W-1:0]             idx, idx_n;
    logic [1:0]                   ch, ch_n;
    logic [3:0]                   kr, kr_n, kc, kc_n;
    logic [9:0]                   orow, orow_n;
    logic [10:0]                  ocol, ocol_n;
    logic signed [ACC_WIDTH-1:0]  acc, acc_n, shifted;
    logic signed [2*DATA_WIDTH-1:0] prod;
    logic [DATA_WIDTH-1:0]        result;
    logic [DATA_WIDTH-1:0]        wmem [MAX_W_WORDS];
    logic [IDX_W-1:0]             nw, nw_last;
    logic [ADDR_WIDTH-1:0]        plane, w_base, of_base, tap_row, tap_col, addr_n;
    logic                         last_out;

    assign dbg_state = state;
    assign nw        = IDX_W'(ACCELERATOR_W_CHANNELS) * IDX_W'(ACCELERATOR_W_ROWS)
                     * IDX_W'(ACCELERATOR_W_COLUMS);
    assign nw_last   = nw - IDX_W'(1);
    assign prod      = $signed(ACCELERATOR_DATA_IN) * $signed(wmem[idx]);
    assign last_out  = (orow == ACCELERATOR_OF_ROWS - 10'd1)
                    && (ocol == ACCELERATOR_OF_COLUMS - 11'd1);

    always_comb begin
        state_n = state;
        idx_n   = idx;
        ch_n    = ch;
        kr_n    = kr;
        kc_n    = kc;
        orow_n  = orow;
        ocol_n  = ocol;
        acc_n   = acc;
        case (state)
            S_IDLE: if (ACCELERATOR_START) begin
                idx_n   = '0;
                ch_n    = '0;
                kr_n    = '0;
                kc_n    = '0;
                orow_n  = '0;
                ocol_n  = '0;
                state_n = ACCELERATOR_SAME_W ? S_CONV_RD : S_W_RD;
            end
            S_W_RD: state_n = S_W_CAP;
            S_W_CAP: begin
                if (idx == nw_last) begin
                    idx_n   = '0;
                    state_n = S_CONV_RD;
                end else begin
                    idx_n   = idx + IDX_W'(1);
                    state_n = S_W_RD;
                end
            end
            S_CONV_RD: state_n = S_CONV_MAC;
            S_CONV_MAC: begin
                // The first tap of every output restarts the sum instead of adding to it.
                acc_n = ((idx == '0) ? '0 : acc)
                      + {{(ACC_WIDTH-2*DATA_WIDTH){prod[2*DATA_WIDTH-1]}}, prod};
                if (idx == nw_last) begin
                    idx_n   = '0;
                    ch_n    = '0;
                    kr_n    = '0;
                    kc_n    = '0;
                    state_n = S_WRITE;
                end else begin
                    idx_n   = idx + IDX_W'(1);
                    state_n = S_CONV_RD;
                    if (kc == ACCELERATOR_W_COLUMS - 4'd1) begin
                        kc_n = '0;
                        if (kr == ACCELERATOR_W_ROWS - 4'd1) begin
                            kr_n = '0;
                            ch_n = ch + 2'd1;
                        end else begin
                            kr_n = kr + 4'd1;
                        end
                    end else begin
                        kc_n = kc + 4'd1;
                    end
                end
            end
            S_WRITE: begin
                if (last_out) begin
                    state_n = S_DONE;
                end else begin
                    state_n = S_CONV_RD;
                    if (ocol == ACCELERATOR_OF_COLUMS - 11'd1) begin
                        ocol_n = '0;
                        orow_n = orow + 10'd1;
                    end else begin
                        ocol_n = ocol + 11'd1;
                    end
                end
            end
            S_DONE: if (ACCELERATOR_FINISHED_OK) state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase
    end

    assign shifted = acc_n >>> FRAC_BITS;

    always_comb begin
        if (shifted > SAT_MAX)      result = SAT_MAX[DATA_WIDTH-1:0];
        else if (shifted < SAT_MIN) result = SAT_MIN[DATA_WIDTH-1:0];
        else                        result = shifted[DATA_WIDTH-1:0];
`ifdef RELU_EN
        if (result[DATA_WIDTH-1]) result = '0;
`endif
    end

    // Outputs are registered, so the address is built from the counters of the state being entered.
    always_comb begin
        plane   = ADDR_WIDTH'(ACCELERATOR_IF_ROWS) * ADDR_WIDTH'(ACCELERATOR_IF_COLUMS);
        w_base  = ACCELERATOR_ADDR_OFFSET + ADDR_WIDTH'(ACCELERATOR_IF_CHANNELS) * plane;
        of_base = w_base + ADDR_WIDTH'(nw);
        tap_row = ADDR_WIDTH'(orow_n) * ADDR_WIDTH'(ACCELERATOR_CONV_STRIDE) + ADDR_WIDTH'(kr_n);
        tap_col = ADDR_WIDTH'(ocol_n) * ADDR_WIDTH'(ACCELERATOR_CONV_STRIDE) + ADDR_WIDTH'(kc_n);
        addr_n  = '0;
        case (state_n)
            S_W_RD:    addr_n = w_base + ADDR_WIDTH'(idx_n);
            S_CONV_RD: addr_n = ACCELERATOR_ADDR_OFFSET + ADDR_WIDTH'(ch_n) * plane
                              + tap_row * ADDR_WIDTH'(ACCELERATOR_IF_COLUMS) + tap_col;
            S_WRITE:   addr_n = of_base + ADDR_WIDTH'(orow_n) * ADDR_WIDTH'(ACCELERATOR_OF_COLUMS)
                              + ADDR_WIDTH'(ocol_n);
            default:   addr_n = '0;
        endcase
    end

    always_ff @(posedge ACCELERATOR_Clk_50 or negedge ACCELERATOR_Reset) begin
        if (!ACCELERATOR_Reset) begin
            state                <= S_IDLE;
            idx                  <= '0;
            ch                   <= '0;
            kr                   <= '0;
            kc                   <= '0;
            orow                 <= '0;
            ocol                 <= '0;
            acc                  <= '0;
            ACCELERATOR_MEM_RE   <= 1'b0;
            ACCELERATOR_MEM_WE   <= 1'b0;
            ACCELERATOR_MEM_ADDR <= '0;
            ACCELERATOR_DATA_OUT <= '0;
            ACCELERATOR_FINISHED <= 1'b0;
        end else begin
            state                <= state_n;
            idx                  <= idx_n;
            ch                   <= ch_n;
            kr                   <= kr_n;
            kc                   <= kc_n;
            orow                 <= orow_n;
            ocol                 <= ocol_n;
            acc                  <= acc_n;
            ACCELERATOR_MEM_RE   <= (state_n == S_W_RD) || (state_n == S_CONV_RD);
            ACCELERATOR_MEM_WE   <= (state_n == S_WRITE);
            ACCELERATOR_MEM_ADDR <= addr_n;
            ACCELERATOR_DATA_OUT <= (state_n == S_WRITE) ? result : '0;
            ACCELERATOR_FINISHED <= (state_n == S_DONE);
        end
    end

    always_ff @(posedge ACCELERATOR_Clk_50 or negedge ACCELERATOR_Reset) begin
        if (!ACCELERATOR_Reset) begin
            for (int i = 0; i < MAX_W_WORDS; i++) wmem[i] <= '0;
        end else if (state == S_W_CAP) begin
            wmem[idx] <= ACCELERATOR_DATA_IN;
        end
    end
endmodule

// File: tb/tb_conv_accelerator.sv
// Bench for conv_accelerator: RAM model, directed and random convolutions checked against a
// plain-arithmetic reference model; honours RELU_EN the same way as the design.
module tb_conv_accelerator;
    logic tb_clk_50 = 1'b0;
    always #10 tb_clk_50 = ~tb_clk_50;

    logic        rst_n, start, fin_ok, same_w;
    logic [15:0] data_in;
    logic [31:0] offset;
    logic [9:0]  if_rows, of_rows;
    logic [10:0] if_cols, of_cols;
    logic [1:0]  n_ch;
    logic [3:0]  w_rows, w_cols, stride;
    logic [15:0] data_out;
    logic [31:0] mem_addr;
    logic        mem_we, mem_re, finished;
    logic [2:0]  dbg_state;

    conv_accelerator dut (
        .ACCELERATOR_Clk_50(tb_clk_50), .ACCELERATOR_Reset(rst_n),
        .ACCELERATOR_DATA_IN(data_in), .ACCELERATOR_ADDR_OFFSET(offset),
        .ACCELERATOR_IF_ROWS(if_rows), .ACCELERATOR_IF_COLUMS(if_cols),
        .ACCELERATOR_IF_CHANNELS(n_ch), .ACCELERATOR_OF_ROWS(of_rows),
        .ACCELERATOR_OF_COLUMS(of_cols), .ACCELERATOR_W_ROWS(w_rows),
        .ACCELERATOR_W_COLUMS(w_cols), .ACCELERATOR_W_CHANNELS(n_ch),
        .ACCELERATOR_SAME_W(same_w), .ACCELERATOR_CONV_STRIDE(stride),
        .ACCELERATOR_START(start), .ACCELERATOR_FINISHED_OK(fin_ok),
        .ACCELERATOR_DATA_OUT(data_out), .ACCELERATOR_MEM_ADDR(mem_addr),
        .ACCELERATOR_MEM_WE(mem_we), .ACCELERATOR_MEM_RE(mem_re),
        .ACCELERATOR_FINISHED(finished), .dbg_state(dbg_state)
    );

    logic [15:0] exp_q[$];
    logic [31:0] exp_addr_q[$];
    int          checks = 0, errors = 0;
    int          ifm[768];
    int          wts[675];
    logic [15:0] ram[4096];
    int          wt_rd_cnt, wr_cnt, conflict_cnt, rst_access_cnt, oob_cnt;
    logic [31:0] wlo, whi;

    // RAM model: one-cycle read latency, single-cycle write.
    always @(posedge tb_clk_50) begin
        if (mem_re && mem_we) conflict_cnt++;
        if (!rst_n && (mem_re || mem_we)) rst_access_cnt++;
        if ((mem_re || mem_we) && mem_addr >= 32'd4096) oob_cnt++;
        if (mem_re && mem_addr >= wlo && mem_addr < whi) wt_rd_cnt++;
        if (mem_re) data_in <= ram[mem_addr[11:0]];
        if (mem_we) begin
            ram[mem_addr[11:0]] <= data_out;
            wr_cnt++;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic set_cfg(input int c, input int ir, input int ic, input int wr, input int wc,
                           input int st, input int off);
        n_ch = 2'(c); if_rows = 10'(ir); if_cols = 11'(ic); w_rows = 4'(wr); w_cols = 4'(wc);
        stride = 4'(st); offset = 32'(off);
        of_rows = 10'((ir - wr) / st + 1);
        of_cols = 11'((ic - wc) / st + 1);
        wlo = 32'(off + c * ir * ic);
        whi = wlo + 32'(c * wr * wc);
    endtask

    task automatic randomize_data(input int amp);
        for (int i = 0; i < 768; i++) ifm[i] = int'($urandom_range(0, 2 * amp)) - amp;
        for (int i = 0; i < 675; i++) wts[i] = int'($urandom_range(0, 2 * amp)) - amp;
    endtask

    // Lays out IF then weights in RAM, and derives the expected OF from the convolution definition.
    task automatic load_and_model();
        int nif, nw, base;
        longint acc, r;
        nif = int'(n_ch) * int'(if_rows) * int'(if_cols);
        nw  = int'(n_ch) * int'(w_rows) * int'(w_cols);
        for (int i = 0; i < 4096; i++) ram[i] = 16'hA5A5;
        for (int i = 0; i < nif; i++) ram[int'(offset) + i] = 16'(ifm[i]);
        for (int i = 0; i < nw; i++) ram[int'(offset) + nif + i] = 16'(wts[i]);
        exp_q.delete();
        exp_addr_q.delete();
        base = int'(offset) + nif + nw;
        for (int orr = 0; orr < int'(of_rows); orr++)
            for (int oc = 0; oc < int'(of_cols); oc++) begin
                acc = 0;
                for (int c = 0; c < int'(n_ch); c++)
                    for (int kr = 0; kr < int'(w_rows); kr++)
                        for (int kc = 0; kc < int'(w_cols); kc++)
                            acc += longint'(ifm[c * int'(if_rows) * int'(if_cols)
                                   + (orr * int'(stride) + kr) * int'(if_cols) + oc * int'(stride) + kc])
                                 * longint'(wts[(c * int'(w_rows) + kr) * int'(w_cols) + kc]);
                r = acc >>> 8;
                if (r > 32767) r = 32767;
                if (r < -32768) r = -32768;
`ifdef RELU_EN
                if (r < 0) r = 0;
`endif
                exp_q.push_back(16'(r));
                exp_addr_q.push_back(32'(base + orr * int'(of_cols) + oc));
            end
    endtask

    task automatic run_conv(input string tag, input logic sw);
        int cyc, nw, lat;
        nw  = int'(n_ch) * int'(w_rows) * int'(w_cols);
        lat = (sw ? 0 : 2 * nw) + int'(of_rows) * int'(of_cols) * (2 * nw + 1);
        wt_rd_cnt = 0;
        wr_cnt = 0;
        @(negedge tb_clk_50);
        same_w = sw;
        start = 1'b1;
        @(posedge tb_clk_50);
        #1 start = 1'b0;
        cyc = 0;
        while (!finished && cyc < 20000) begin
            @(posedge tb_clk_50);
            #1 cyc++;
        end
        check({tag, " finished"}, 32'(finished), 32'd1);
        check({tag, " latency"}, 32'(cyc), 32'(lat));
        repeat (3) @(posedge tb_clk_50);
        #1 check({tag, " finished held"}, 32'(finished), 32'd1);
        @(negedge tb_clk_50);
        fin_ok = 1'b1;
        @(posedge tb_clk_50);
        #1 fin_ok = 1'b0;
        check({tag, " finished cleared"}, 32'(finished), 32'd0);
    endtask

    task automatic verify_of(input string tag);
        check({tag, " write count"}, 32'(wr_cnt), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size(); i++)
            check({tag, " of word"}, 32'(ram[exp_addr_q[i][11:0]]), 32'(exp_q[i]));
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b1; fin_ok = 1'b0; same_w = 1'b0; data_in = '0;
        wlo = '0; whi = '0;
        wt_rd_cnt = 0; wr_cnt = 0; conflict_cnt = 0; rst_access_cnt = 0; oob_cnt = 0;
        set_cfg(1, 3, 3, 2, 2, 1, 9);

        // Reset held with START asserted
        repeat (5) @(posedge tb_clk_50);
        #1;
        check("reset re", 32'(mem_re), 32'd0);
        check("reset we", 32'(mem_we), 32'd0);
        check("reset finished", 32'(finished), 32'd0);
        check("reset addr", mem_addr, 32'd0);
        check("reset dout", 32'(data_out), 32'd0);
        check("reset access", 32'(rst_access_cnt), 32'd0);
        @(negedge tb_clk_50);
        start = 1'b0;
        rst_n = 1'b1;
        repeat (3) @(posedge tb_clk_50);
        #1 check("idle after reset", 32'(dbg_state), 32'd0);
        check("idle no read", 32'(mem_re), 32'd0);

        // 3x3 IF 1..9, 2x2 weights of 1.0
        for (int i = 0; i < 9; i++) ifm[i] = i + 1;
        for (int i = 0; i < 4; i++) wts[i] = 256;
        load_and_model();
        run_conv("d1", 1'b0);
        check("d1 of0", 32'(ram[22]), 32'd12);
        check("d1 of1", 32'(ram[23]), 32'd16);
        check("d1 of2", 32'(ram[24]), 32'd24);
        check("d1 of3", 32'(ram[25]), 32'd28);
        check("d1 weight reads", 32'(wt_rd_cnt), 32'd4);
        verify_of("d1");

        // 5x5 IF 0..24, 1x1 weight, stride 2
        set_cfg(1, 5, 5, 1, 1, 2, 0);
        for (int i = 0; i < 25; i++) ifm[i] = i;
        wts[0] = 256;
        load_and_model();
        run_conv("d2", 1'b0);
        for (int i = 0; i < 9; i++) begin
            int r, c;
            r = i / 3;
            c = i % 3;
            check("d2 stride of", 32'(ram[26 + i]), 32'(r * 10 + c * 2));
        end

        // Positive saturation, then negative saturation reusing the stored weights
        set_cfg(3, 2, 2, 2, 2, 1, 100);
        for (int i = 0; i < 12; i++) begin
            ifm[i] = 32767;
            wts[i] = 32767;
        end
        load_and_model();
        run_conv("sat_pos", 1'b0);
        check("sat_pos of", 32'(ram[124]), 32'h7FFF);
        for (int i = 0; i < 12; i++) ifm[i] = -32768;
        load_and_model();
        run_conv("sat_neg", 1'b1);
`ifdef RELU_EN
        check("sat_neg of", 32'(ram[124]), 32'h0000);
`else
        check("sat_neg of", 32'(ram[124]), 32'h8000);
`endif
        check("sat_neg weight reads", 32'(wt_rd_cnt), 32'd0);

        // Random configurations, each re-run with SAME_W
        for (int t = 0; t < 4; t++) begin
            int wr, wc, st;
            wr = int'($urandom_range(1, 3));
            wc = int'($urandom_range(1, 3));
            st = int'($urandom_range(1, 2));
            set_cfg(int'($urandom_range(1, 3)), wr + int'($urandom_range(0, 4)),
                    wc + int'($urandom_range(0, 4)), wr, wc, st, int'($urandom_range(0, 300)));
            case (t % 3)
                0: randomize_data(127);
                1: randomize_data(2047);
                default: randomize_data(32767);
            endcase
            load_and_model();
            run_conv("rand", 1'b0);
            verify_of("rand");
            for (int i = 0; i < exp_addr_q.size(); i++) ram[exp_addr_q[i][11:0]] = 16'hDEAD;
            run_conv("rand same_w", 1'b1);
            verify_of("rand same_w");
            check("rand same_w weight reads", 32'(wt_rd_cnt), 32'd0);
        end

        // Reset in the middle of a convolution, then a clean run
        set_cfg(2, 4, 4, 2, 2, 1, 40);
        randomize_data(1023);
        load_and_model();
        @(negedge tb_clk_50);
        same_w = 1'b0;
        start = 1'b1;
        @(posedge tb_clk_50);
        #1 start = 1'b0;
        repeat (30) @(posedge tb_clk_50);
        #3 rst_n = 1'b0;
        #1;
        check("abort re", 32'(mem_re), 32'd0);
        check("abort we", 32'(mem_we), 32'd0);
        check("abort finished", 32'(finished), 32'd0);
        check("abort state", 32'(dbg_state), 32'd0);
        rst_access_cnt = 0;
        repeat (3) @(posedge tb_clk_50);
        #1 check("abort no access", 32'(rst_access_cnt), 32'd0);
        @(negedge tb_clk_50);
        rst_n = 1'b1;
        load_and_model();
        run_conv("after abort", 1'b0);
        verify_of("after abort");

        check("re/we overlap", 32'(conflict_cnt), 32'd0);
        check("out of range access", 32'(oob_cnt), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/conv_accelerator.md
Name: conv_accelerator

Overview:
Single-engine 2-D convolution accelerator for CNN layers. It reads weights and a multi-channel input feature map (IF) from an off-chip word-addressed RAM, computes one output feature map (OF) plane by sequential multiply-accumulate, and writes the OF back to the same RAM. A host configures it through static size and offset inputs and a START/FINISHED/FINISHED_OK handshake.

Parameters:
DATA_WIDTH, 16, RAM word and pixel/weight width (signed two's complement).
ADDR_WIDTH, 32, RAM address width.
FRAC_BITS, 8, fractional bits of the fixed-point format; product sum is shifted right by this amount.
ACC_WIDTH, 40, accumulator width.
MAX_W_WORDS, 675, weight store depth (15x15x3).

Ports:
ACCELERATOR_Clk_50  in  1  system clock; all logic on its rising edge.
ACCELERATOR_Reset  in  1  asynchronous, active-low reset.
ACCELERATOR_DATA_IN  in  16  RAM read data, valid the cycle after a read request.
ACCELERATOR_ADDR_OFFSET  in  32  base address of the IF.
ACCELERATOR_IF_ROWS  in  10  IF height.
ACCELERATOR_IF_COLUMS  in  11  IF width.
ACCELERATOR_IF_CHANNELS  in  2  IF channels (1..3).
ACCELERATOR_OF_ROWS  in  10  OF height (supplied by host).
ACCELERATOR_OF_COLUMS  in  11  OF width (supplied by host).
ACCELERATOR_W_ROWS  in  4  kernel height (1..15).
ACCELERATOR_W_COLUMS  in  4  kernel width (1..15).
ACCELERATOR_W_CHANNELS  in  2  kernel channels; equals IF_CHANNELS.
ACCELERATOR_SAME_W  in  1  1 at START: reuse stored weights, skip weight load.
ACCELERATOR_CONV_STRIDE  in  4  stride (1..15), same both axes.
ACCELERATOR_START  in  1  start request, sampled in IDLE.
ACCELERATOR_FINISHED_OK  in  1  host acknowledge of FINISHED.
ACCELERATOR_DATA_OUT  out  16  RAM write data.
ACCELERATOR_MEM_ADDR  out  32  RAM address.
ACCELERATOR_MEM_WE  out  1  RAM write enable.
ACCELERATOR_MEM_RE  out  1  RAM read enable.
ACCELERATOR_FINISHED  out  1  convolution complete.

Behaviour:
- Reset (asynchronous, Reset=0): FSM to IDLE, all outputs 0, accumulator and counters 0, weight store 0. Reset mid-operation aborts immediately; no further RAM access.
- All outputs registered; MEM_RE and MEM_WE never high together.
- Memory map: NIF = IF_CHANNELS*IF_ROWS*IF_COLUMS, NW = W_CHANNELS*W_ROWS*W_COLUMS. IF at ADDR_OFFSET + ch*IF_ROWS*IF_COLUMS + r*IF_COLUMS + c. Weights at ADDR_OFFSET + NIF + ch*W_ROWS*W_COLUMS + kr*W_COLUMS + kc. OF at ADDR_OFFSET + NIF + NW + r*OF_COLUMS + c.
- RAM read protocol: cycle t drive MEM_RE=1 and MEM_ADDR; DATA_IN valid and captured at t+1. Write: one cycle MEM_WE=1 with MEM_ADDR and DATA_OUT.
- States: IDLE -> (START=1: SAME_W=1 ? CONV_RD : W_RD). W_RD (request weight i) -> W_CAP (store DATA_IN at i) -> W_RD until i=NW-1, then CONV_RD. CONV_RD (request IF tap) -> CONV_MAC (acc += DATA_IN*weight) -> CONV_RD until last tap -> WRITE -> next output or DONE. DONE: FINISHED=1 held until FINISHED_OK=1, then FINISHED=0, IDLE.
- Tap order per output: channel, kernel row, kernel column. Output order: row-major. IF tap coordinate = (r*STRIDE+kr, c*STRIDE+kc). Accumulator cleared at first tap of each output.
- Latency: 2*NW cycles weight load (0 if SAME_W), then per output 2*NW+1 cycles; FINISHED rises the cycle after the last write.
- Arithmetic: signed 16x16 -> 32-bit product, sign-extended into ACC_WIDTH accumulator. Result = acc >>> FRAC_BITS (arithmetic), saturated to [-32768, 32767].
- START while busy or in DONE ignored. OF sizes not checked; host guarantees OF_ROWS = (IF_ROWS-W_ROWS)/STRIDE+1 (same for columns).

Optional Feature:
RELU_EN: when defined, negative saturated results are written as 0 (ReLU). When undefined, signed result written unchanged.

Test Plan:
- Reset held low with START=1 -> no RAM access, all outputs 0; release, IDLE.
- 1ch 3x3 IF values 1..9, 2x2 weights 0x0100, stride 1, offset 9 -> OF at addr 22..25 = 12,16,24,28; FINISHED after 8+4*9 cycles; held until FINISHED_OK.
- 1ch 5x5 IF values 0..24, 1x1 weight 0x0100, stride 2 -> 3x3 OF = 0,2,4,10,12,14,20,22,24.
- 3ch 2x2 IF all 0x7FFF, 2x2 weights 0x7FFF -> saturates to 0x7FFF; all -0x8000 times 0x7FFF -> 0x8000 (0 with RELU_EN).
- Second run with SAME_W=1 -> no weight-region reads, identical OF.
- Reset low mid-convolution -> RE/WE/FINISHED drop immediately; new START completes normally.
